// File: rtl/decode_q_pkg.sv
// Shared types, default field geometry and immediate-extension helper for
// the buffered instruction-decode stage.
package decode_q_pkg;

    typedef enum logic [1:0] {
        IMM_ZERO  = 2'b00,
        IMM_SIGN  = 2'b01,
        IMM_UPPER = 2'b10,
        IMM_RSVD  = 2'b11
    } imm_mode_e;

    localparam int INSTR_W_DEF  = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int OPCODE_W_DEF = 4;
    localparam int IMM_W_DEF    = 12;
    localparam int ADDR_W_DEF   = 10;
    localparam int CC_W_DEF     = 2;
    localparam int DEPTH_DEF    = 2;

    // Working width for the helper; callers truncate to their DATA_W.
    localparam int EXT_W = 64;

    function automatic logic [EXT_W-1:0] extend_imm(
        input logic [EXT_W-1:0] imm,
        input imm_mode_e        mode,
        input int               imm_w,
        input int               data_w
    );
        logic [EXT_W-1:0] mask;
        logic [EXT_W-1:0] field;
        mask  = (EXT_W'(1) << imm_w) - EXT_W'(1);
        field = imm & mask;
        case (mode)
            IMM_SIGN:  extend_imm = (|(field & (EXT_W'(1) << (imm_w - 1)))) ? (field | ~mask) : field;
            IMM_UPPER: extend_imm = field << (data_w - imm_w);
            default:   extend_imm = field;
        endcase
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small power-of-two FIFO holding instruction words queued behind the IR.
module instr_fifo
    import decode_q_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [INSTR_W-1:0] din_i,
    output logic [INSTR_W-1:0] dout_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CNT_W-1:0]   count_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/decode_stage_q.sv
// Buffered decode stage: FIFO-fed instruction register with field decode,
// selectable immediate extension and a consumption-qualified compcode latch.
module decode_stage_q
    import decode_q_pkg::*;
#(
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int OPCODE_W = OPCODE_W_DEF,
    parameter int IMM_W    = IMM_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int CC_W     = CC_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    localparam int LVL_W   = $clog2(DEPTH + 2),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [INSTR_W-1:0]   mem_out,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic [1:0]           imm_mode,
    input  logic                 out_ready,
    input  logic                 ccw,
    output logic                 out_valid,
    output logic [OPCODE_W-1:0]  ir_opcode,
    output logic [ADDR_W-1:0]    ir_address,
    output logic [IMM_W-1:0]     ir_immediate,
    output logic [CC_W-1:0]      ir_compcode,
    output logic [DATA_W-1:0]    imm_out,
    output logic [CC_W-1:0]      compcode_out,
    output logic [LVL_W-1:0]     level
);

    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [CC_W-1:0]    cc_q, cc_d;

    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [INSTR_W-1:0] fifo_head, src_word;
    logic [CNT_W-1:0]   fifo_count;
    logic               in_fire, out_fire, ir_slot, bypass;

    instr_fifo #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (reset),
        .flush_i (flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (mem_out),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // in_ready never looks at out_ready, so a full FIFO blocks input even
    // while the IR is being consumed.
    assign in_ready = !fifo_full && !flush;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q && out_ready;
    assign ir_slot  = !valid_q || out_fire;

    // The FIFO head has priority; an empty FIFO lets the input bypass into the IR.
    assign fifo_pop  = ir_slot && !fifo_empty && !flush;
    assign bypass    = ir_slot && fifo_empty && in_fire;
    assign fifo_push = in_fire && !bypass;
    assign src_word  = fifo_empty ? mem_out : fifo_head;

    always_comb begin
        ir_d    = ir_q;
        valid_d = valid_q;
        imm_d   = imm_q;
        cc_d    = cc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (fifo_pop || bypass) begin
            ir_d    = src_word;
            valid_d = 1'b1;
            imm_d   = DATA_W'(extend_imm(EXT_W'(src_word[IMM_W-1:0]),
                                         imm_mode_e'(imm_mode), IMM_W, DATA_W));
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
        if (out_fire && ccw && !flush) cc_d = ir_q[ADDR_W+CC_W-1:ADDR_W];
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            ir_q    <= '0;
            valid_q <= 1'b0;
            imm_q   <= '0;
            cc_q    <= '0;
        end else begin
            ir_q    <= ir_d;
            valid_q <= valid_d;
            imm_q   <= imm_d;
            cc_q    <= cc_d;
        end
    end

    assign out_valid    = valid_q;
    assign ir_opcode    = ir_q[INSTR_W-1 -: OPCODE_W];
    assign ir_address   = ir_q[ADDR_W-1:0];
    assign ir_immediate = ir_q[IMM_W-1:0];
    assign ir_compcode  = ir_q[ADDR_W+CC_W-1:ADDR_W];
    assign imm_out      = imm_q;
    assign compcode_out = cc_q;
    assign level        = LVL_W'(fifo_count) + LVL_W'(valid_q);

endmodule
